alu_seq: RTL

Parametrised, handshaked successor to the datapath's combinational ALU. It keeps the ADD/AND/NOT/PASS encodings and adds SUB, logical shift-left, arithmetic shift-right and an iterative multi-cycle multiply. It registers the result together with NZP/carry/overflow flags behind a valid/ready interface. It sits between the register file read ports and the bus/condition-code logic, so a multiply can stall the datapath without stalling the FSM's clock.

---
 rtl/alu_seq_pkg.sv | 47 ++++
 rtl/alu_seq_mul.sv | 73 +++++++
 rtl/alu_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pkg
//  Purpose  : Shared types and helpers for the sequential ALU.
//             - alu_op_t : 3-bit ALUK operation encodings
//             - state_t  : control FSM state encodings
//             - calc_nzp : {N,Z,P} of a result of arbitrary width
//  Revision : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_AND  = 3'b001,
    OP_NOT  = 3'b010,
    OP_PASS = 3'b011,
    OP_SUB  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SRA  = 3'b110,
    OP_MUL  = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest result calc_nzp can classify; callers zero-extend into this.
  localparam int c_nzp_max_width = 64;

  // The sign bit is located with a mask rather than a variable index so the
  // helper works for any result width up to c_nzp_max_width. Zero-extension
  // by the caller keeps the zero test exact.
  function automatic logic [2:0] calc_nzp(input logic [c_nzp_max_width-1:0] result,
                                          input int width);
    logic [c_nzp_max_width-1:0] msb_mask;
    logic                       n;
    logic                       z;
    msb_mask = c_nzp_max_width'(1) << (width - 1);
    n        = |(result & msb_mask);
    z        = (result == '0);
    return {n, z, !n && !z};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_mul.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_mul
//  Purpose  : Iterative unsigned shift-add multiplier, one partial product per
//             cycle, low WIDTH bits of the product.
//  Ports    : clk       - rising-edge clock
//             rst       - synchronous active-high reset
//             i_start   - capture operands and begin (ignored while busy)
//             i_a, i_b  - multiplicand / multiplier
//             o_busy    - an iteration is in progress
//             o_done    - final iteration this cycle; o_product is the result
//             o_product - running sum including this cycle's partial product
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq_mul #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam logic [SHW-1:0] c_last_iter = SHW'(WIDTH - 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] w_sum;

  // Multiplier is shifted right so bit 0 always selects the current partial
  // product; the multiplicand shifts left to the matching weight.
  assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + SHW'(1);
      if (r_cnt == c_last_iter) begin
        r_busy <= 1'b0;
      end
    end
  end

  // The last partial product is folded in combinationally so the consumer can
  // register the complete product WIDTH edges after the start edge.
  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == c_last_iter);
  assign o_product = w_sum;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Handshaked ALU with registered result and NZP/carry/overflow
//             flags. Single-cycle ops complete at the accept edge; MUL runs
//             through the iterative multiplier for WIDTH cycles.
//  Ports    : Clk, Reset          - clock, synchronous active-high reset
//             in_valid / in_ready - operation handshake
//             Input_A, Input_B    - operands (B[SHW-1:0] = shift amount)
//             ALUK                - op select (see alu_op_t)
//             out_valid/out_ready - result handshake
//             ALU_out, nzp, carry, ovf - registered result and flags
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Input_A,
  input  logic [WIDTH-1:0] Input_B,
  input  logic [2:0]       ALUK,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_out,
  output logic [2:0]       nzp,
  output logic             carry,
  output logic             ovf
);

  localparam logic [1:0] c_st_idle = IDLE;
  localparam logic [1:0] c_st_mul  = MUL;
  localparam logic [1:0] c_st_done = DONE;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_alu_out;
  logic [2:0]       r_nzp;
  logic             r_carry;
  logic             r_ovf;

  alu_op_t          w_op;
  logic             w_accept;
  logic             w_is_sub;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;
  logic             w_add_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_mul_start;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;

  assign w_op = alu_op_t'(ALUK);

  // Handshake signals decode from the state register; Reset only masks
  // in_ready so nothing is offered during the reset cycle itself.
  assign in_ready  = (r_state == c_st_idle) && !Reset;
  assign out_valid = (r_state == c_st_done);
  assign w_accept  = in_valid && in_ready;

  // SUB shares the adder as A + ~B + 1, so carry-out is the NOT-borrow.
  assign w_is_sub  = (w_op == OP_SUB);
  assign w_addend  = w_is_sub ? ~Input_B : Input_B;
  assign w_sum     = {1'b0, Input_A} + {1'b0, w_addend} + {{WIDTH{1'b0}}, w_is_sub};
  assign w_add_ovf = (Input_A[WIDTH-1] == w_addend[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != Input_A[WIDTH-1]);

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = w_add_ovf;
      end
      OP_AND:  w_res = Input_A & Input_B;
      OP_NOT:  w_res = ~Input_A;
      OP_PASS: w_res = Input_A;
      OP_SHL:  w_res = Input_A << Input_B[SHW-1:0];
      OP_SRA:  w_res = WIDTH'($signed(Input_A) >>> Input_B[SHW-1:0]);
      default: w_res = '0;
    endcase
  end

  assign w_mul_start = w_accept && (w_op == OP_MUL);

  alu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk       (Clk),
    .rst       (Reset),
    .i_start   (w_mul_start),
    .i_a       (Input_A),
    .i_b       (Input_B),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= c_st_idle;
      r_alu_out <= '0;
      r_nzp     <= 3'b010;
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            if (w_op == OP_MUL) begin
              r_state <= c_st_mul;
            end else begin
              r_state   <= c_st_done;
              r_alu_out <= w_res;
              r_nzp     <= calc_nzp(c_nzp_max_width'(w_res), WIDTH);
              r_carry   <= w_carry;
              r_ovf     <= w_ovf;
            end
          end
        end
        c_st_mul: begin
          if (w_mul_done) begin
            r_state   <= c_st_done;
            r_alu_out <= w_mul_product;
            r_nzp     <= calc_nzp(c_nzp_max_width'(w_mul_product), WIDTH);
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
          end else if (!w_mul_busy) begin
            // Multiplier idle while we wait on it: drop the op rather than hang.
            r_state <= c_st_idle;
          end
        end
        c_st_done: begin
          if (out_ready) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign ALU_out = r_alu_out;
  assign nzp     = r_nzp;
  assign carry   = r_carry;
  assign ovf     = r_ovf;

endmodule
`default_nettype wire
